exe_branch_unit: RTL and testbench
==================================

# exe_branch_unit

Parametrised branch/jump execution unit with a direction predictor. It resolves B-type, JAL and JALR instructions in EXE and indexes a branch history table (BHT) of 2-bit saturating counters, which fetch queries for a taken/not-taken prediction. It issues a registered redirect on any direction or target mismatch, and keeps saturating branch and mispredict statistics. It sits between decode/EXE and the PC/fetch control.

## Interface
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, operand width (≥ ADDR_WIDTH)
- BHT_DEPTH, 64, BHT entries; power of two, ≥2
- CNT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken)
- STAT_WIDTH, 32, width of statistics counters
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- pred_pc_i  in  ADDR_WIDTH  fetch PC to predict
- pred_taken_o  out  1  MSB of BHT[idx(pred_pc_i)], combinational
- valid_i  in  1  EXE holds a valid instruction
- inst_i  in  DATA_WIDTH  instruction word
- inst_addr_i  in  ADDR_WIDTH  PC of inst_i
- op1_i, op2_i  in  DATA_WIDTH  rs1 / rs2 values
- pred_taken_i  in  1  prediction made for this instruction at fetch
- redirect_o  out  1  registered: flush younger stages and load redirect_addr_o
- redirect_addr_o  out  ADDR_WIDTH  registered correct next PC
- misalign_o  out  1  registered: taken target not 4-byte aligned
- bad_addr_o  out  ADDR_WIDTH  registered offending target
- branch_cnt_o, mispred_cnt_o  out  STAT_WIDTH  saturating statistics

## Operation
- idx(pc) = pc[log2(BHT_DEPTH)+1:2].
- A resolve is accepted when valid_i=1, redirect_o=0 and misalign_o=0. Instructions presented while either output is high are wrong-path: no BHT update, no statistics, no outputs.
- B-type: taken is BEQ (op1==op2), BNE (!=), BLT/BGE (signed <, >=), BLTU/BGEU (unsigned). Target = inst_addr_i + B-imm (sign-extended, bit0=0). Unknown funct3: treated as a non-branch.
- JAL: always taken. Target = inst_addr_i + J-imm.
- JALR: always taken. Target = (op1_i + sign-extended I-imm) & ~1, truncated to ADDR_WIDTH.
- Fall-through = inst_addr_i + 4. All adds wrap modulo 2^ADDR_WIDTH.
- Mispredict conditions:
  - B-type: taken != pred_taken_i.
  - JAL: pred_taken_i=0.
  - JALR: always, because fetch has no target for it.
- Misalign: a taken branch or jump whose target[1]=1. This has priority over redirect. Set misalign_o=1 and bad_addr_o=target, with redirect_o=0 and no BHT update. Statistics still count it.
- Redirect on mispredict without misalign: redirect_o=1, redirect_addr_o = taken ? target : fall-through.
- BHT update, accepted B-type only (including mispredicts):
  - taken: counter +1, saturating at 2'b11.
  - not taken: counter −1, saturating at 2'b00.
  - JAL/JALR never update.
- Statistics, per accepted B/JAL/JALR:
  - branch_cnt_o +1; mispred_cnt_o +1 when mispredicted.
  - Both hold at all-ones.
- Non-branch opcodes: no effect; outputs go to 0 next cycle.

## Timing
- All outputs except pred_taken_o are registered, with one-cycle latency. Resolve in cycle N gives redirect_o / misalign_o in cycle N+1, high for exactly one cycle.
- misalign_o is a one-cycle pulse; upstream trap logic takes over from there.
- BHT write lands at the end of cycle N. pred_taken_o in cycle N shows the old value, with no forwarding; from cycle N+1 it shows the new value, including when pred_pc_i matches the updated index.
- Back-to-back accepted branches (no redirect between them) update the BHT every cycle. Two consecutive updates to the same index both apply.
- rst_n_i low, at any time, including mid-redirect:
  - redirect_o, misalign_o, redirect_addr_o, bad_addr_o = 0.
  - Both statistics counters = 0.
  - All BHT entries = CNT_INIT.
  - Effect is immediate and asynchronous; release is synchronous to the next clk_i edge.

## Test plan
- Reset, then BEQ at 0x100 with op1=op2=5, pred_taken_i=0, imm=+16 -> next cycle redirect_o=1, redirect_addr_o=0x110; BHT[idx(0x100)] 01→10; pred_taken_o for 0x100 = 1; mispred_cnt_o=1.
- Same BEQ, taken, repeated 4× with correct prediction -> counter saturates at 11, no redirect after the first; branch_cnt_o=5 total with the first case.
- BLT with op1=0xFFFFFFFF, op2=1 -> taken. BLTU with the same operands -> not taken; with pred_taken_i=1, redirect to inst_addr+4.
- JALR, op1=0x203, imm=+0 -> target 0x202 -> misalign_o=1, bad_addr_o=0x202, redirect_o=0. JALR op1=0x201 -> target 0x200, redirect_o=1.
- Mispredicted BNE followed next cycle by valid BEQ -> BEQ ignored: no BHT change, branch_cnt_o unchanged.
- Assert rst_n_i during a redirect_o=1 cycle -> outputs drop to 0 immediately, BHT back to CNT_INIT, counters cleared.

Source files
------------

// File: rtl/exe_branch_unit.sv
// Branch/jump resolve unit for EXE with a 2-bit-counter BHT predictor.
// Resolves B-type, JAL and JALR. It registers a redirect or a misalign trap
// one cycle after an accepted resolve, and keeps saturating statistics.
module exe_branch_unit #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         BHT_DEPTH  = 64,
  parameter logic [1:0] CNT_INIT   = 2'b01,
  parameter int         STAT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] pred_pc_i,
  output logic                  pred_taken_o,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] inst_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic                  pred_taken_i,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_addr_o,
  output logic                  misalign_o,
  output logic [ADDR_WIDTH-1:0] bad_addr_o,
  output logic [STAT_WIDTH-1:0] branch_cnt_o,
  output logic [STAT_WIDTH-1:0] mispred_cnt_o
);
  localparam int         IDX_W     = $clog2(BHT_DEPTH);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  misalign;
    logic [ADDR_WIDTH-1:0] bad_addr;
  } resp_t;

  resp_t resp_d, resp_q;

  logic [1:0]            bht [BHT_DEPTH];
  logic [IDX_W-1:0]      pred_idx, upd_idx;
  logic [1:0]            upd_cnt;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] b_imm, j_imm;
  logic [DATA_WIDTH-1:0] i_imm, jalr_sum;
  logic [ADDR_WIDTH-1:0] target, fall_thru;
  logic                  is_br, is_jal, is_jalr, is_ctl, br_cond;
  logic                  taken, mispred, mis_al, accept, do_ctl, bht_we;
  logic [STAT_WIDTH-1:0] branch_cnt_q, mispred_cnt_q;
  logic                  unused_ok;

  assign opcode   = inst_i[6:0];
  assign funct3   = inst_i[14:12];
  assign b_imm    = {{(ADDR_WIDTH-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign j_imm    = {{(ADDR_WIDTH-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign i_imm    = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
  assign jalr_sum = op1_i + i_imm;

  assign pred_idx     = pred_pc_i[IDX_W+1:2];
  assign upd_idx      = inst_addr_i[IDX_W+1:2];
  assign upd_cnt      = bht[upd_idx];
  // No forwarding: a same-cycle update is only visible from the next cycle.
  assign pred_taken_o = bht[pred_idx][1];

  // Keeps wide/partially-used buses referenced as a whole.
  assign unused_ok = ^{pred_pc_i, inst_i, jalr_sum};

  // Classify the instruction and evaluate the branch condition.
  always_comb begin
    is_br   = 1'b0;
    br_cond = 1'b0;
    is_jal  = (opcode == OP_JAL);
    is_jalr = (opcode == OP_JALR);
    if (opcode == OP_BRANCH) begin
      is_br = 1'b1;
      case (funct3)
        3'b000:  br_cond = (op1_i == op2_i);
        3'b001:  br_cond = (op1_i != op2_i);
        3'b100:  br_cond = ($signed(op1_i) <  $signed(op2_i));
        3'b101:  br_cond = ($signed(op1_i) >= $signed(op2_i));
        3'b110:  br_cond = (op1_i <  op2_i);
        3'b111:  br_cond = (op1_i >= op2_i);
        default: is_br   = 1'b0;  // unknown funct3 behaves as a non-branch
      endcase
    end
  end

  // Target, mispredict and misalign resolution, plus next registered response.
  always_comb begin
    is_ctl    = is_br | is_jal | is_jalr;
    taken     = is_br ? br_cond : (is_jal | is_jalr);
    fall_thru = inst_addr_i + ADDR_WIDTH'(4);
    if (is_jalr) target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
    else         target = inst_addr_i + (is_jal ? j_imm : b_imm);
    // JALR always redirects: fetch never has a target for it.
    mispred = is_br ? (taken != pred_taken_i) : (is_jal ? ~pred_taken_i : is_jalr);
    mis_al  = taken & target[1];
    // Anything arriving while a redirect/trap is in flight is wrong-path.
    accept  = valid_i & ~resp_q.redirect & ~resp_q.misalign;
    do_ctl  = accept & is_ctl;
    bht_we  = do_ctl & is_br & ~mis_al;
    resp_d  = '0;
    if (do_ctl) begin
      if (mis_al) begin
        resp_d.misalign = 1'b1;
        resp_d.bad_addr = target;
      end else if (mispred) begin
        resp_d.redirect      = 1'b1;
        resp_d.redirect_addr = taken ? target : fall_thru;
      end
    end
  end

  // Registered response: one-cycle pulses, cleared whenever nothing resolves.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) resp_q <= '0;
    else          resp_q <= resp_d;
  end

  // BHT counters: saturating increment on taken, decrement on not-taken.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_INIT;
    end else if (bht_we) begin
      if (taken) begin
        if (upd_cnt != 2'b11) bht[upd_idx] <= upd_cnt + 2'b01;
      end else begin
        if (upd_cnt != 2'b00) bht[upd_idx] <= upd_cnt - 2'b01;
      end
    end
  end

  // Saturating statistics; misaligned jumps/branches still count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (do_ctl) begin
      if (branch_cnt_q != '1)             branch_cnt_q  <= branch_cnt_q + 1'b1;
      if (mispred && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  assign redirect_o      = resp_q.redirect;
  assign redirect_addr_o = resp_q.redirect_addr;
  assign misalign_o      = resp_q.misalign;
  assign bad_addr_o      = resp_q.bad_addr;
  assign branch_cnt_o    = branch_cnt_q;
  assign mispred_cnt_o   = mispred_cnt_q;

endmodule

// File: tb/tb_exe_branch_unit.sv
// Bench for exe_branch_unit: directed scenarios followed by random traffic,
// all checked against a behavioural model of the resolve rules.
module tb_exe_branch_unit;
  logic        clk, rst_n;
  logic [31:0] pred_pc, inst, inst_addr, op1, op2;
  logic        pred_taken_o, valid, pred_taken_in;
  logic        redirect, misalign;
  logic [31:0] redirect_addr, bad_addr, branch_cnt, mispred_cnt;

  exe_branch_unit dut (
    .clk_i(clk), .rst_n_i(rst_n), .pred_pc_i(pred_pc), .pred_taken_o(pred_taken_o),
    .valid_i(valid), .inst_i(inst), .inst_addr_i(inst_addr), .op1_i(op1), .op2_i(op2),
    .pred_taken_i(pred_taken_in), .redirect_o(redirect), .redirect_addr_o(redirect_addr),
    .misalign_o(misalign), .bad_addr_o(bad_addr), .branch_cnt_o(branch_cnt),
    .mispred_cnt_o(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: counters per BHT entry, statistics, in-flight outputs.
  int          m_bht [64];
  int          m_br, m_mp;
  bit          m_red, m_mis;
  logic [31:0] e_ra, e_bad;

  localparam int K_NONE = 0, K_B = 1, K_JAL = 2, K_JALR = 3;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_br = 0; m_mp = 0; m_red = 0; m_mis = 0; e_ra = 0; e_bad = 0;
  endtask

  function automatic logic [31:0] enc_b(logic [2:0] f3, int imm);
    logic [12:0] i;
    i = 13'(imm);
    return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(int imm);
    logic [20:0] i;
    i = 21'(imm);
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  // One EXE cycle: drive, check prediction, advance model, check outputs.
  task automatic run(bit v, int kind, logic [2:0] f3, int imm, logic [31:0] addr,
                     logic [31:0] a, logic [31:0] b, bit pt, logic [31:0] ppc);
    bit          acc, br, ctl, tk, mp, ma;
    logic [31:0] tgt;
    case (kind)
      K_B:     inst = enc_b(f3, imm);
      K_JAL:   inst = enc_jal(imm);
      K_JALR:  inst = enc_jalr(imm);
      default: inst = {25'($urandom), 7'b0010011};
    endcase
    valid = v; inst_addr = addr; op1 = a; op2 = b; pred_taken_in = pt; pred_pc = ppc;
    #1;
    chk("pred_taken", pred_taken_o, m_bht[(ppc >> 2) % 64] >= 2);

    acc = v && !m_red && !m_mis;
    br  = (kind == K_B) && (f3 != 3'd2) && (f3 != 3'd3);
    ctl = br || kind == K_JAL || kind == K_JALR;
    tk  = 0;
    if (br) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) <  $signed(b));
        3'd5: tk = ($signed(a) >= $signed(b));
        3'd6: tk = (a <  b);
        default: tk = (a >= b);
      endcase
    end else if (kind == K_JAL || kind == K_JALR) tk = 1;
    if (kind == K_JALR) tgt = (a + 32'(imm)) & ~32'd1;
    else                tgt = addr + 32'(imm);
    mp = br ? (tk != pt) : (kind == K_JAL) ? !pt : (kind == K_JALR);
    ma = tk && tgt[1];

    m_red = 0; m_mis = 0; e_ra = 0; e_bad = 0;
    if (acc && ctl) begin
      m_br++;
      if (mp) m_mp++;
      if (ma) begin
        m_mis = 1; e_bad = tgt;
      end else if (mp) begin
        m_red = 1; e_ra = tk ? tgt : addr + 32'd4;
      end
      if (br && !ma) begin
        if (tk) m_bht[(addr >> 2) % 64] = (m_bht[(addr >> 2) % 64] == 3) ? 3 : m_bht[(addr >> 2) % 64] + 1;
        else    m_bht[(addr >> 2) % 64] = (m_bht[(addr >> 2) % 64] == 0) ? 0 : m_bht[(addr >> 2) % 64] - 1;
      end
    end

    @(posedge clk); #1;
    chk("redirect",      redirect,      m_red);
    chk("redirect_addr", redirect_addr, e_ra);
    chk("misalign",      misalign,      m_mis);
    chk("bad_addr",      bad_addr,      e_bad);
    chk("branch_cnt",    branch_cnt,    m_br);
    chk("mispred_cnt",   mispred_cnt,   m_mp);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          nb, kind, imm;
    logic [31:0] a, b, addr, ppc;
    rst_n = 0; valid = 0; inst = 0; inst_addr = 0; op1 = 0; op2 = 0;
    pred_taken_in = 0; pred_pc = 32'h100;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_redirect", redirect, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_raddr",    redirect_addr, 0);
    chk("rst_bcnt",     branch_cnt, 0);
    chk("rst_pred",     pred_taken_o, 0);
    rst_n = 1;

    // Mispredicted taken BEQ trains 01->10 and redirects to 0x110.
    run(1, K_B, 3'd0, 16, 32'h100, 32'd5, 32'd5, 0, 32'h100);
    chk("tp1_redirect", redirect, 1);
    chk("tp1_raddr",    redirect_addr, 32'h110);
    chk("tp1_mpcnt",    mispred_cnt, 1);
    pred_pc = 32'h100; #1;
    chk("tp1_pred", pred_taken_o, 1);
    run(0, K_NONE, 3'd0, 0, 32'h0, 0, 0, 0, 32'h100);

    // Correctly predicted repeats saturate the counter without redirects.
    repeat (4) run(1, K_B, 3'd0, 16, 32'h100, 32'd5, 32'd5, 1, 32'h100);
    chk("tp2_bcnt",     branch_cnt, 5);
    chk("tp2_redirect", redirect, 0);
    chk("tp2_mpcnt",    mispred_cnt, 1);

    // Signed vs unsigned compare on the same operands.
    run(1, K_B, 3'd4, 8, 32'h200, 32'hFFFF_FFFF, 32'd1, 1, 32'h200);
    chk("blt_redirect", redirect, 0);
    run(1, K_B, 3'd6, 8, 32'h204, 32'hFFFF_FFFF, 32'd1, 1, 32'h204);
    chk("bltu_raddr", redirect_addr, 32'h208);
    run(0, K_NONE, 3'd0, 0, 32'h0, 0, 0, 0, 32'h204);

    // JALR misalign has priority over redirect; aligned JALR redirects.
    run(1, K_JALR, 3'd0, 0, 32'h400, 32'h203, 0, 1, 32'h400);
    chk("jalr_mis",  misalign, 1);
    chk("jalr_bad",  bad_addr, 32'h202);
    chk("jalr_nred", redirect, 0);
    run(0, K_NONE, 3'd0, 0, 32'h0, 0, 0, 0, 32'h400);
    run(1, K_JALR, 3'd0, 0, 32'h404, 32'h201, 0, 1, 32'h404);
    chk("jalr_red",   redirect, 1);
    chk("jalr_raddr", redirect_addr, 32'h200);
    run(0, K_NONE, 3'd0, 0, 32'h0, 0, 0, 0, 32'h404);

    // Wrong-path BEQ right after a mispredicted BNE is dropped.
    nb = m_br;
    run(1, K_B, 3'd1, 32, 32'h300, 32'd1, 32'd2, 0, 32'h300);
    run(1, K_B, 3'd0, 32, 32'h300, 32'd7, 32'd7, 0, 32'h300);
    chk("wp_bcnt",  branch_cnt, nb + 1);
    chk("wp_nored", redirect, 0);
    run(0, K_NONE, 3'd0, 0, 32'h0, 0, 0, 0, 32'h300);

    // Random traffic over a small PC window so BHT entries collide.
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 5);
      if (kind > 3) kind = K_B;
      a    = rand_op();
      b    = ($urandom_range(0, 2) == 0) ? a : rand_op();
      addr = 32'($urandom_range(0, 127)) << 2;
      ppc  = $urandom_range(0, 1) ? addr : 32'($urandom_range(0, 127)) << 2;
      case (kind)
        K_B:     imm = int'($urandom_range(0, 4095)) * 2 - 4096;
        K_JAL:   imm = int'($urandom_range(0, 1048575)) * 2 - 1048576;
        K_JALR:  imm = int'($urandom_range(0, 4095)) - 2048;
        default: imm = 0;
      endcase
      run($urandom_range(0, 7) != 0, kind, 3'($urandom), imm, addr, a, b,
          1'($urandom), ppc);
    end

    // Reset asserted while a redirect is being presented.
    run(0, K_NONE, 3'd0, 0, 32'h0, 0, 0, 0, 32'h100);
    repeat (3) run(1, K_B, 3'd0, 16, 32'h100, 32'd5, 32'd5, 1, 32'h100);
    run(1, K_B, 3'd1, 16, 32'h104, 32'd3, 32'd4, 0, 32'h100);
    chk("pre_rst_redirect", redirect, 1);
    pred_pc = 32'h100;
    rst_n = 0; #1;
    chk("mid_rst_redirect", redirect, 0);
    chk("mid_rst_raddr",    redirect_addr, 0);
    chk("mid_rst_misalign", misalign, 0);
    chk("mid_rst_bad",      bad_addr, 0);
    chk("mid_rst_bcnt",     branch_cnt, 0);
    chk("mid_rst_mpcnt",    mispred_cnt, 0);
    chk("mid_rst_pred",     pred_taken_o, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    run(1, K_B, 3'd0, 16, 32'h100, 32'd5, 32'd5, 0, 32'h100);
    run(0, K_NONE, 3'd0, 0, 32'h0, 0, 0, 0, 32'h100);
    run(1, K_JAL, 3'd0, 64, 32'h500, 0, 0, 1, 32'h500);
    run(1, K_JAL, 3'd0, 64, 32'h504, 0, 0, 0, 32'h504);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
